// File: rtl/dot_pkg.sv
// dot_pkg
// Shared constants and helpers for the dot_pipe_n dot-product pipeline.
//   ROUND_* : selects how the fixed-point sum is scaled back down
//   SAT_*   : selects what happens when the scaled value does not fit
//   sum_width() : width of an exact sum of vec_len full-width products
package dot_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Each product needs 2*data_width bits; adding vec_len of them can grow
  // the magnitude by up to clog2(vec_len) more bits.
  function automatic int sum_width(input int data_width, input int vec_len);
    return 2 * data_width + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/dot_scale_sat.sv
// dot_scale_sat
// Combinational fixed-point scaling of the exact dot-product sum:
// optional round-half-up, arithmetic right shift by Q_BITS, overflow
// detection against the signed DATA_WIDTH range, then clamp or wrap.
// Ports:
//   sum    in  SUM_WIDTH   exact signed sum of products
//   result out DATA_WIDTH  scaled, clamped or wrapped value
//   ovf    out 1           scaled value did not fit in DATA_WIDTH
module dot_scale_sat
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SUM_WIDTH  = 66,
  parameter int Q_BITS     = 10,
  parameter int ROUND      = ROUND_TRUNC,
  parameter int SAT        = SAT_CLAMP
) (
  input  logic signed [SUM_WIDTH-1:0]  sum,
  output logic        [DATA_WIDTH-1:0] result,
  output logic                         ovf
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int EW = SUM_WIDTH + 1;

  localparam logic signed [EW-1:0] MAX_V =
    {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V =
    {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [DATA_WIDTH-1:0] MAX_OUT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_OUT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] scaled;

  assign ext = EW'(sum);

  // With Q_BITS = 0 there is no fractional part, so there is nothing to round.
  generate
    if (ROUND == ROUND_HALF_UP && Q_BITS > 0) begin : g_round
      localparam logic signed [EW-1:0] HALF = EW'(1) << (Q_BITS - 1);
      assign rounded = ext + HALF;
    end else begin : g_trunc
      assign rounded = ext;
    end
  endgenerate

  assign scaled = rounded >>> Q_BITS;

  assign ovf = (scaled > MAX_V) || (scaled < MIN_V);

  // Clamp toward the bound on the same side as the true value; otherwise
  // just keep the low bits (which is also the in-range answer).
  always_comb begin
    result = scaled[DATA_WIDTH-1:0];
    if (SAT == SAT_CLAMP && ovf) begin
      result = scaled[EW-1] ? MIN_OUT : MAX_OUT;
    end
  end

endmodule

// File: rtl/dot_pipe_n.sv
// dot_pipe_n
// Three-stage signed fixed-point dot-product pipeline between a
// first-word-fall-through input FIFO and an output FIFO.
//   S1: VEC_LEN full-width products
//   S2: exact sum of the products
//   S3: scaled / rounded / saturated result plus overflow flag
// All stages advance together; the only stall source is a full
// downstream FIFO while S3 holds a result.
// Ports:
//   clock     in  1                     rising-edge clock
//   reset     in  1                     synchronous, active-low
//   x, y      in  VEC_LEN x DATA_WIDTH  operand vectors (element i = x[i])
//   in_empty  in  1                     upstream FIFO empty
//   in_rd_en  out 1                     pop one x/y pair
//   out       out DATA_WIDTH            result
//   out_ovf   out 1                     result overflowed before clamp/wrap
//   out_full  in  1                     downstream FIFO full
//   out_wr_en out 1                     write out/out_ovf downstream
module dot_pipe_n
  import dot_pkg::*;
#(
  parameter int VEC_LEN    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 10,
  parameter int ROUND      = ROUND_TRUNC,
  parameter int SAT        = SAT_CLAMP
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]  x,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]  y,
  input  logic                                in_empty,
  output logic                                in_rd_en,
  output logic [DATA_WIDTH-1:0]               out,
  output logic                                out_ovf,
  input  logic                                out_full,
  output logic                                out_wr_en
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = sum_width(DATA_WIDTH, VEC_LEN);

  logic                 en;
  logic                 v1;
  logic                 v2;
  logic                 v3;
  logic signed [PW-1:0] prod_q [VEC_LEN];
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] sum_q;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  ovf_d;

  // Only a valid result that cannot leave blocks the pipe; bubbles in S3
  // let everything behind it move up regardless of out_full.
  assign en = !(v3 && out_full);

  // Handshakes are gated by reset so nothing moves while reset is held,
  // including the cycle before the first reset edge has cleared v3.
  assign in_rd_en  = reset && !in_empty && en;
  assign out_wr_en = reset && v3 && !out_full;

  // Valid bits and the S3 result register are the only reset state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      out     <= '0;
      out_ovf <= 1'b0;
    end else if (en) begin
      v1 <= in_rd_en;
      v2 <= v1;
      v3 <= v2;
      if (v2) begin
        out     <= res_d;
        out_ovf <= ovf_d;
      end
    end
  end

  // Datapath registers load only alongside a valid bit and otherwise hold.
  always_ff @(posedge clock) begin
    if (in_rd_en) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        prod_q[i] <= PW'($signed(x[i])) * PW'($signed(y[i]));
      end
    end
    if (en && v1) begin
      sum_q <= sum_d;
    end
  end

  // Exact sum: every product is sign-extended to the full sum width first.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      sum_d = sum_d + SW'(prod_q[i]);
    end
  end

  dot_scale_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .SUM_WIDTH (SW),
    .Q_BITS    (Q_BITS),
    .ROUND     (ROUND),
    .SAT       (SAT)
  ) u_scale_sat (
    .sum   (sum_q),
    .result(res_d),
    .ovf   (ovf_d)
  );

endmodule

// File: tb/tb_dot_pipe_n.sv
// tb_dot_pipe_n
// Drives three dot_pipe_n instances in lockstep (truncate+clamp,
// round+clamp, truncate+wrap) from a modelled FWFT source queue.
// Expected results are pushed when a pop is seen and compared when the
// design writes. Instance index: 0 = trunc/clamp, 1 = round/clamp,
// 2 = trunc/wrap.
module tb_dot_pipe_n;

  typedef struct packed {
    logic [2:0][31:0] x;
    logic [2:0][31:0] y;
  } vec_t;

  typedef struct packed {
    logic [2:0][31:0] out;
    logic [2:0]       ovf;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [2:0][31:0] x = '0;
  logic [2:0][31:0] y = '0;
  logic             in_empty = 1'b1;
  logic             out_full = 1'b0;

  logic        rd_m, rd_r, rd_w;
  logic        wr_m, wr_r, wr_w;
  logic [31:0] out_m, out_r, out_w;
  logic        ovf_m, ovf_r, ovf_w;

  vec_t src_q[$];
  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  logic [2:0] obs_rd;
  logic [2:0] obs_wr;
  exp_t obs;

  always #5 clock = ~clock;

  dot_pipe_n #(.VEC_LEN(3), .DATA_WIDTH(32), .Q_BITS(10), .ROUND(0), .SAT(1)) u_dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty), .in_rd_en(rd_m),
    .out(out_m), .out_ovf(ovf_m), .out_full(out_full), .out_wr_en(wr_m));

  dot_pipe_n #(.VEC_LEN(3), .DATA_WIDTH(32), .Q_BITS(10), .ROUND(1), .SAT(1)) u_rnd (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty), .in_rd_en(rd_r),
    .out(out_r), .out_ovf(ovf_r), .out_full(out_full), .out_wr_en(wr_r));

  dot_pipe_n #(.VEC_LEN(3), .DATA_WIDTH(32), .Q_BITS(10), .ROUND(0), .SAT(0)) u_wrap (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty), .in_rd_en(rd_w),
    .out(out_w), .out_ovf(ovf_w), .out_full(out_full), .out_wr_en(wr_w));

  // Reference: exact 128-bit sum, scale, then clamp or wrap to 32 bits.
  function automatic logic [32:0] model(input vec_t v, input bit rnd, input bit sat);
    logic signed [127:0] s;
    logic                o_ovf;
    logic [31:0]         o;
    s = '0;
    for (int i = 0; i < 3; i++) begin
      s = s + 128'($signed(v.x[i])) * 128'($signed(v.y[i]));
    end
    if (rnd) s = s + (128'sd1 <<< 9);
    s = s >>> 10;
    o_ovf = (s > 128'sd2147483647) || (s < -128'sd2147483648);
    o = s[31:0];
    if (sat && o_ovf) o = s[127] ? 32'h80000000 : 32'h7FFFFFFF;
    return {o_ovf, o};
  endfunction

  function automatic exp_t make_exp(input vec_t v);
    logic [32:0] a, b, c;
    exp_t e;
    a = model(v, 1'b0, 1'b1);
    b = model(v, 1'b1, 1'b1);
    c = model(v, 1'b0, 1'b0);
    e.out = {c[31:0], b[31:0], a[31:0]};
    e.ovf = {c[32], b[32], a[32]};
    return e;
  endfunction

  function automatic vec_t mk(input int x0, x1, x2, y0, y1, y2);
    vec_t v;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2;
    v.y[0] = y0; v.y[1] = y1; v.y[2] = y2;
    return v;
  endfunction

  // Mix of small values (exact, in range) and full-range ones (overflow).
  function automatic vec_t rand_vec();
    vec_t v;
    int   t;
    for (int i = 0; i < 3; i++) begin
      t = int'($urandom_range(0, 80000)) - 40000;
      v.x[i] = ($urandom_range(0, 3) == 0) ? $urandom : t;
      t = int'($urandom_range(0, 80000)) - 40000;
      v.y[i] = ($urandom_range(0, 3) == 0) ? $urandom : t;
    end
    return v;
  endfunction

  // First-word-fall-through source: head of src_q is always on x/y.
  task automatic drive_src();
    if (src_q.size() == 0) begin
      in_empty = 1'b1;
      x = '0;
      y = '0;
    end else begin
      in_empty = 1'b0;
      x = src_q[0].x;
      y = src_q[0].y;
    end
  endtask

  // One clock: present source, sample at the falling edge, record a pop.
  task automatic cycle();
    drive_src();
    @(negedge clock);
    obs_rd  = {rd_w, rd_r, rd_m};
    obs_wr  = {wr_w, wr_r, wr_m};
    obs.out = {out_w, out_r, out_m};
    obs.ovf = {ovf_w, ovf_r, ovf_m};
    if (obs_rd[0] && src_q.size() > 0) exp_q.push_back(make_exp(src_q.pop_front()));
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    out_full = 1'b0;
    src_q.push_back(mk(1024, 2048, -1024, 1024, 1024, 1024));
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (obs_rd !== 3'b000 || obs_wr !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_handshake: rd=%b wr=%b, expected rd=000 wr=000", obs_rd, obs_wr);
      end
    end
    checks++;
    if (obs.out !== '0 || obs.ovf !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: out=%h ovf=%b, expected all zero", obs.out, obs.ovf);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    cycle();
    checks++;
    if (obs_rd !== 3'b111) begin
      errors++;
      $display("[TB] FAIL first_pop: rd=%b, expected 111", obs_rd);
    end
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++;
      if (obs_wr !== ((k == 3) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("[TB] FAIL basic_latency: cycle T+%0d wr=%b, expected %b", k, obs_wr, (k == 3) ? 3'b111 : 3'b000);
      end
    end
    if (obs_wr[0]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL basic_result: unexpected write out=%h", obs.out);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("[TB] FAIL basic_result: got out=%h ovf=%b, expected out=%h ovf=%b", obs.out, obs.ovf, e.out, e.ovf);
        end
      end
      checks++;
      if (obs.out[0] !== 32'd2048 || obs.ovf[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_value: got out=%0d ovf=%b, expected out=2048 ovf=0", $signed(obs.out[0]), obs.ovf[0]);
      end
    end
  endtask

  task automatic test_rounding();
    exp_t        e;
    int          n = 0;
    logic [31:0] want_trunc [2];
    logic [31:0] want_round [2];
    want_trunc[0] = 32'h0;        want_round[0] = 32'h1;
    want_trunc[1] = 32'hFFFFFFFF; want_round[1] = 32'h0;
    src_q.push_back(mk(1, 0, 0, 512, 0, 0));
    src_q.push_back(mk(-1, 0, 0, 1, 0, 0));
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (obs_wr[0]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL round_result: unexpected write out=%h", obs.out);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("[TB] FAIL round_result: got out=%h ovf=%b, expected out=%h ovf=%b", obs.out, obs.ovf, e.out, e.ovf);
          end
        end
        if (n < 2) begin
          checks++;
          if (obs.out[0] !== want_trunc[n] || obs.out[1] !== want_round[n]) begin
            errors++;
            $display("[TB] FAIL round_value: result %0d trunc=%h round=%h, expected trunc=%h round=%h", n, obs.out[0], obs.out[1], want_trunc[n], want_round[n]);
          end
        end
        n++;
      end
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("[TB] FAIL round_count: writes=%0d, expected 2", n);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int   n = 0;
    src_q.push_back(mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF));
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (obs_wr[0]) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sat_result: unexpected write out=%h", obs.out);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("[TB] FAIL sat_result: got out=%h ovf=%b, expected out=%h ovf=%b", obs.out, obs.ovf, e.out, e.ovf);
          end
        end
        checks++;
        if (obs.out[0] !== 32'h7FFFFFFF || obs.out[2] !== 32'hFF400000 || obs.ovf !== 3'b111) begin
          errors++;
          $display("[TB] FAIL sat_value: clamp=%h wrap=%h ovf=%b, expected clamp=7fffffff wrap=ff400000 ovf=111", obs.out[0], obs.out[2], obs.ovf);
        end
      end
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("[TB] FAIL sat_count: writes=%0d, expected 1", n);
    end
  endtask

  // Stall rising in the same cycle the source becomes non-empty.
  task automatic test_stall_priority();
    exp_t e;
    src_q.push_back(rand_vec());
    for (int c = 0; c < 3; c++) cycle();
    out_full = 1'b1;
    src_q.push_back(rand_vec());
    for (int c = 0; c < 2; c++) begin
      cycle();
      checks++;
      if (obs_rd !== 3'b000 || obs_wr !== 3'b000) begin
        errors++;
        $display("[TB] FAIL stall_priority: rd=%b wr=%b, expected rd=000 wr=000", obs_rd, obs_wr);
      end
    end
    out_full = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (obs_wr[0]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stall_result: unexpected write out=%h", obs.out);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("[TB] FAIL stall_result: got out=%h ovf=%b, expected out=%h ovf=%b", obs.out, obs.ovf, e.out, e.ovf);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL stall_drain: pending=%0d unpopped=%0d, expected 0 0", exp_q.size(), src_q.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n = 0;
    for (int i = 0; i < 8; i++) src_q.push_back(rand_vec());
    for (int c = 0; c < 30; c++) begin
      out_full = (c >= 4 && c <= 8);
      cycle();
      if (out_full) begin
        checks++;
        if (obs_rd !== 3'b000 || obs_wr !== 3'b000) begin
          errors++;
          $display("[TB] FAIL bp_stall: cycle %0d rd=%b wr=%b, expected rd=000 wr=000", c, obs_rd, obs_wr);
        end
      end
      if (obs_wr[0]) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_result: unexpected write out=%h", obs.out);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("[TB] FAIL bp_result: got out=%h ovf=%b, expected out=%h ovf=%b", obs.out, obs.ovf, e.out, e.ovf);
          end
        end
      end
    end
    out_full = 1'b0;
    checks++;
    if (n !== 8 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_count: writes=%0d pending=%0d, expected writes=8 pending=0", n, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [2:0] want;
    for (int i = 0; i < 16; i++) src_q.push_back(rand_vec());
    for (int c = 0; c < 22; c++) begin
      cycle();
      if (c < 16) begin
        checks++;
        if (obs_rd !== 3'b111) begin
          errors++;
          $display("[TB] FAIL stream_pop: cycle %0d rd=%b, expected 111", c, obs_rd);
        end
      end
      want = (c >= 3 && c <= 18) ? 3'b111 : 3'b000;
      checks++;
      if (obs_wr !== want) begin
        errors++;
        $display("[TB] FAIL stream_write: cycle %0d wr=%b, expected %b", c, obs_wr, want);
      end
      if (obs_wr[0]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_result: unexpected write out=%h", obs.out);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("[TB] FAIL stream_result: got out=%h ovf=%b, expected out=%h ovf=%b", obs.out, obs.ovf, e.out, e.ovf);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int   n = 0;
    for (int i = 0; i < 3; i++) src_q.push_back(rand_vec());
    for (int c = 0; c < 3; c++) cycle();
    reset = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      cycle();
      checks++;
      if (obs_wr !== 3'b000 || obs_rd !== 3'b000) begin
        errors++;
        $display("[TB] FAIL midreset_hold: rd=%b wr=%b, expected rd=000 wr=000", obs_rd, obs_wr);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (obs_wr !== 3'b000 || obs.out !== '0 || obs.ovf !== '0) begin
        errors++;
        $display("[TB] FAIL midreset_after: wr=%b out=%h ovf=%b, expected wr=000 out=0 ovf=000", obs_wr, obs.out, obs.ovf);
      end
    end
    src_q.push_back(rand_vec());
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (obs_wr[0]) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL midreset_result: unexpected write out=%h", obs.out);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("[TB] FAIL midreset_result: got out=%h ovf=%b, expected out=%h ovf=%b", obs.out, obs.ovf, e.out, e.ovf);
          end
        end
      end
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("[TB] FAIL midreset_count: writes=%0d, expected 1", n);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_stall_priority();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
